// File: rtl/enemy_respawn_scheduler_if.sv
// Bus between the enemy alive datapath and the group respawn scheduler.
interface enemy_respawn_scheduler_if #(
   parameter int ENEMY_COUNT = 23
);
   logic                   frame_tick;
   logic                   game_active;
   logic [ENEMY_COUNT-1:0] enemy_alive;
   logic                   reset_fly;
   logic                   reset_spider;
   logic                   reset_mosquito;
   logic [7:0]             wave_count;
   logic [15:0]            kill_count;

   modport master (
      output frame_tick, game_active, enemy_alive,
      input  reset_fly, reset_spider, reset_mosquito, wave_count, kill_count
   );

   modport slave (
      input  frame_tick, game_active, enemy_alive,
      output reset_fly, reset_spider, reset_mosquito, wave_count, kill_count
   );
endinterface

// File: rtl/enemy_respawn_scheduler.sv
// Group respawn scheduler: wipe-out detection, per-group frame delay, fixed-priority
// respawn pulse arbiter and wave counter. Define KILL_COUNT_EN to build the kill counter.
//
// state | meaning
// ALIVE | group has a live member; watching for wipe-out
// WAIT  | group wiped out; counting frames down to respawn
// READY | requesting a respawn pulse from the arbiter
// GUARD | pulse issued; masking stale alive bits for 2 cycles
module enemy_respawn_scheduler #(
   parameter int ENEMY_COUNT  = 23,
   parameter int FLY_LAST     = 16,
   parameter int SPIDER_LAST  = 20,
   parameter int FLY_DELAY    = 60,
   parameter int SPIDER_DELAY = 90,
   parameter int MOSQ_DELAY   = 120,
   parameter int DELAY_W      = 8
) (
   input logic                      clk25,
   input logic                      rst_n,
   enemy_respawn_scheduler_if.slave bus
);
   localparam int N_GRP = 3;

   typedef enum logic [1:0] {ST_ALIVE, ST_WAIT, ST_READY, ST_GUARD} state_e;
   typedef logic [DELAY_W-1:0] cnt_t;

   function automatic cnt_t grp_delay(input int g);
      case (g)
         0:       return cnt_t'(FLY_DELAY);
         1:       return cnt_t'(SPIDER_DELAY);
         default: return cnt_t'(MOSQ_DELAY);
      endcase
   endfunction

   state_e           state_q [N_GRP];
   state_e           state_d [N_GRP];
   cnt_t             cnt_q   [N_GRP];
   cnt_t             cnt_d   [N_GRP];
   logic [1:0]       guard_q [N_GRP];
   logic [1:0]       guard_d [N_GRP];
   logic [N_GRP-1:0] grp_dead;
   logic [N_GRP-1:0] req;
   logic [N_GRP-1:0] grant;
   logic [N_GRP-1:0] pulse_q;
   logic [N_GRP-1:0] pulse_d;
   logic [7:0]       wave_q;
   logic [7:0]       wave_d;

   assign grp_dead[0] = ~|bus.enemy_alive[FLY_LAST:0];
   assign grp_dead[1] = ~|bus.enemy_alive[SPIDER_LAST:FLY_LAST+1];
   assign grp_dead[2] = ~|bus.enemy_alive[ENEMY_COUNT-1:SPIDER_LAST+1];

   always_comb begin
      req = '0;
      for (int g = 0; g < N_GRP; g++) begin
         req[g] = bus.game_active && (state_q[g] == ST_READY);
      end
   end

   // fly > spider > mosquito
   assign grant[0] = req[0];
   assign grant[1] = req[1] & ~req[0];
   assign grant[2] = req[2] & ~req[1] & ~req[0];

   always_comb begin
      for (int g = 0; g < N_GRP; g++) begin
         state_d[g] = state_q[g];
         cnt_d[g]   = cnt_q[g];
         guard_d[g] = guard_q[g];
         if (bus.game_active) begin
            case (state_q[g])
               ST_ALIVE: begin
                  if (grp_dead[g]) begin
                     if (grp_delay(g) == '0) begin
                        state_d[g] = ST_READY;
                     end else begin
                        cnt_d[g]   = grp_delay(g);
                        state_d[g] = ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (!grp_dead[g]) begin
                     state_d[g] = ST_ALIVE;
                  end else if (bus.frame_tick) begin
                     if (cnt_q[g] == cnt_t'(1)) begin
                        state_d[g] = ST_READY;
                     end else begin
                        cnt_d[g] = cnt_q[g] - cnt_t'(1);
                     end
                  end
               end
               ST_READY: begin
                  if (grant[g]) begin
                     state_d[g] = ST_GUARD;
                     guard_d[g] = 2'd2;
                  end
               end
               ST_GUARD: begin
                  // the alive controller's registered output trails our pulse by a cycle
                  if (guard_q[g] == 2'd1) begin
                     state_d[g] = ST_ALIVE;
                  end else begin
                     guard_d[g] = guard_q[g] - 2'd1;
                  end
               end
               default: state_d[g] = ST_ALIVE;
            endcase
         end
      end
   end

   always_comb begin
      pulse_d = grant;
      wave_d  = wave_q;
      if ((|grant) && (wave_q != 8'hFF)) begin
         wave_d = wave_q + 8'd1;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < N_GRP; g++) begin
            state_q[g] <= ST_GUARD;
            cnt_q[g]   <= '0;
            guard_q[g] <= 2'd2;
         end
         pulse_q <= '0;
         wave_q  <= '0;
      end else begin
         for (int g = 0; g < N_GRP; g++) begin
            state_q[g] <= state_d[g];
            cnt_q[g]   <= cnt_d[g];
            guard_q[g] <= guard_d[g];
         end
         pulse_q <= pulse_d;
         wave_q  <= wave_d;
      end
   end

   assign bus.reset_fly      = pulse_q[0];
   assign bus.reset_spider   = pulse_q[1];
   assign bus.reset_mosquito = pulse_q[2];
   assign bus.wave_count     = wave_q;

`ifdef KILL_COUNT_EN
   localparam int KW = $clog2(ENEMY_COUNT + 1);

   logic [ENEMY_COUNT-1:0] prev_alive_q;
   logic [ENEMY_COUNT-1:0] prev_alive_d;
   logic [15:0]            kill_q;
   logic [15:0]            kill_d;
   logic [KW-1:0]          kills_now;
   logic [16:0]            kill_sum;

   // only 1->0 transitions count; respawns are ignored
   always_comb begin
      kills_now = '0;
      for (int i = 0; i < ENEMY_COUNT; i++) begin
         kills_now = kills_now + KW'(prev_alive_q[i] & ~bus.enemy_alive[i]);
      end
      kill_sum     = {1'b0, kill_q} + 17'(kills_now);
      kill_d       = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      prev_alive_d = bus.enemy_alive;
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         prev_alive_q <= '1;
         kill_q       <= '0;
      end else begin
         prev_alive_q <= prev_alive_d;
         kill_q       <= kill_d;
      end
   end

   assign bus.kill_count = kill_q;
`else
   assign bus.kill_count = '0;
`endif

endmodule

// File: tb/tb_enemy_respawn_scheduler.sv
// Bench for enemy_respawn_scheduler: two instances with different delay sets checked
// every cycle against a frame/queue-level reference model, plus directed scenarios.
`timescale 1ns/1ps
module tb_enemy_respawn_scheduler;
   localparam int EC = 23;

   logic          clk25 = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_tick;
   logic          game_active;
   logic [EC-1:0] alive;

   always #20 clk25 = ~clk25;

   enemy_respawn_scheduler_if #(.ENEMY_COUNT(EC)) bus_a ();
   enemy_respawn_scheduler_if #(.ENEMY_COUNT(EC)) bus_b ();

   assign bus_a.frame_tick  = frame_tick;
   assign bus_a.game_active = game_active;
   assign bus_a.enemy_alive = alive;
   assign bus_b.frame_tick  = frame_tick;
   assign bus_b.game_active = game_active;
   assign bus_b.enemy_alive = alive;

   enemy_respawn_scheduler #(.FLY_DELAY(2), .SPIDER_DELAY(2), .MOSQ_DELAY(2)) u_dut_a (
      .clk25(clk25), .rst_n(rst_n), .bus(bus_a));
   enemy_respawn_scheduler #(.FLY_DELAY(0), .SPIDER_DELAY(5), .MOSQ_DELAY(3)) u_dut_b (
      .clk25(clk25), .rst_n(rst_n), .bus(bus_b));

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: frames left, pending-request flag, guard cycles left
   int dly [2][3] = '{'{2, 2, 2}, '{0, 5, 3}};
   int grp_lo [3] = '{0, 17, 21};
   int grp_hi [3] = '{16, 20, 22};
   int m_left  [2][3];
   bit m_ready [2][3];
   int m_guard [2][3];
   bit m_pulse [2][3];
   int m_wave  [2];
   int m_kill;
   logic [EC-1:0] m_prev;

   int pc      [2][3];
   int last_pe [2][3];
   int edge_n     = 0;
   int tick_total = 0;
   int tick_phase = 0;
   bit rand_tick  = 0;
   int tick_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit grp_dead(input int g);
      for (int i = grp_lo[g]; i <= grp_hi[g]; i++) if (alive[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_kill();
`ifdef KILL_COUNT_EN
      return m_kill;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int g = 0; g < 3; g++) begin
            m_left[d][g]  = 0;
            m_ready[d][g] = 1'b0;
            m_guard[d][g] = 2;
            m_pulse[d][g] = 1'b0;
         end
         m_wave[d] = 0;
      end
      m_kill = 0;
      m_prev = '1;
   endtask

   task automatic model_step();
      int winner;
      int k;
      for (int d = 0; d < 2; d++) begin
         winner = -1;
         if (game_active) for (int g = 2; g >= 0; g--) if (m_ready[d][g]) winner = g;
         for (int g = 0; g < 3; g++) m_pulse[d][g] = (g == winner);
         if (game_active) begin
            for (int g = 0; g < 3; g++) begin
               if (m_guard[d][g] > 0) m_guard[d][g]--;
               else if (m_ready[d][g]) begin
                  if (g == winner) begin
                     m_ready[d][g] = 1'b0;
                     m_guard[d][g] = 2;
                  end
               end else if (m_left[d][g] > 0) begin
                  if (!grp_dead(g)) m_left[d][g] = 0;
                  else if (frame_tick) begin
                     m_left[d][g]--;
                     if (m_left[d][g] == 0) m_ready[d][g] = 1'b1;
                  end
               end else if (grp_dead(g)) begin
                  if (dly[d][g] == 0) m_ready[d][g] = 1'b1;
                  else m_left[d][g] = dly[d][g];
               end
            end
         end
         if (winner >= 0 && m_wave[d] < 255) m_wave[d]++;
      end
      k = m_kill + $countones(m_prev & ~alive);
      m_kill = (k > 65535) ? 65535 : k;
      m_prev = alive;
   endtask

   task automatic get_out(input int d, output logic [2:0] p, output logic [7:0] w,
                          output logic [15:0] k);
      if (d == 0) begin
         p = {bus_a.reset_mosquito, bus_a.reset_spider, bus_a.reset_fly};
         w = bus_a.wave_count;
         k = bus_a.kill_count;
      end else begin
         p = {bus_b.reset_mosquito, bus_b.reset_spider, bus_b.reset_fly};
         w = bus_b.wave_count;
         k = bus_b.kill_count;
      end
   endtask

   task automatic step();
      logic [2:0]  p;
      logic [7:0]  w;
      logic [15:0] k;
      @(posedge clk25);
      edge_n++;
      if (!rst_n) model_reset();
      else begin
         if (frame_tick) begin
            tick_total++;
            tick_q.push_back(edge_n);
         end
         model_step();
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         get_out(d, p, w, k);
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("dut%0d_pulse_grp%0d", d, g), 32'(p[g]), 32'(m_pulse[d][g]));
            if (p[g] === 1'b1) begin
               pc[d][g]++;
               last_pe[d][g] = edge_n;
            end
         end
         chk($sformatf("dut%0d_wave", d), 32'(w), 32'(m_wave[d]));
         chk($sformatf("dut%0d_kill", d), 32'(k), 32'(exp_kill()));
      end
      tick_phase++;
      frame_tick = rand_tick ? ($urandom_range(0, 2) == 0) : (tick_phase % 4 == 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int base [2][3];
      int w0;
      int nt;
      int re;
      bit seen;

      frame_tick  = 1'b0;
      game_active = 1'b1;
      alive       = '1;
      for (int d = 0; d < 2; d++) for (int g = 0; g < 3; g++) begin
         pc[d][g] = 0;
         last_pe[d][g] = 0;
      end
      model_reset();

      // reset release with everybody alive: silence for 1000 cycles
      steps(3);
      #5 rst_n = 1'b1;
      steps(1000);
      for (int d = 0; d < 2; d++) for (int g = 0; g < 3; g++)
         chk($sformatf("idle_pulses_dut%0d_grp%0d", d, g), 32'(pc[d][g]), 32'd0);
      chk("idle_wave_a", 32'(bus_a.wave_count), 32'd0);
      chk("idle_wave_b", 32'(bus_b.wave_count), 32'd0);

      // mosquitoes wiped on the delay-3 instance: one pulse, one cycle after 3rd tick
      base[1][2] = pc[1][2];
      w0 = m_wave[1];
      alive[22:21] = 2'b00;
      step();
      tick_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         if (pc[1][2] != base[1][2]) seen = 1'b1;
      end
      alive[22:21] = 2'b11;
      chk("mosq3_wave_after_pulse", 32'(bus_b.wave_count), 32'(w0 + 1));
      steps(40);
      chk("mosq3_pulse_count", 32'(pc[1][2] - base[1][2]), 32'd1);
      chk("mosq3_enough_ticks", 32'(tick_q.size() >= 3), 32'd1);
      if (tick_q.size() >= 3) chk("mosq3_latency", 32'(last_pe[1][2]), 32'(tick_q[2] + 1));

      // everything wiped, equal delays: fly, spider, mosquito on consecutive cycles
      steps(10);
      for (int g = 0; g < 3; g++) base[0][g] = pc[0][g];
      w0 = m_wave[0];
      alive = '0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         if (pc[0][2] != base[0][2]) seen = 1'b1;
      end
      alive = '1;
      for (int g = 0; g < 3; g++)
         chk($sformatf("all_dead_pulses_grp%0d", g), 32'(pc[0][g] - base[0][g]), 32'd1);
      chk("all_dead_spider_order", 32'(last_pe[0][1]), 32'(last_pe[0][0] + 1));
      chk("all_dead_mosq_order", 32'(last_pe[0][2]), 32'(last_pe[0][0] + 2));
      chk("all_dead_wave", 32'(bus_a.wave_count), 32'(w0 + 3));
      steps(20);

      // spider revives mid-WAIT: no pulse, then a fresh full delay on the next wipe-out
      base[0][1] = pc[0][1];
      base[1][1] = pc[1][1];
      alive[20:17] = 4'b0000;
      step();
      nt = tick_total;
      for (int i = 0; i < 20 && tick_total == nt; i++) step();
      alive[18] = 1'b1;
      steps(40);
      chk("revive_no_pulse_a", 32'(pc[0][1] - base[0][1]), 32'd0);
      chk("revive_no_pulse_b", 32'(pc[1][1] - base[1][1]), 32'd0);
      alive[18] = 1'b0;
      step();
      tick_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         step();
         if (pc[0][1] != base[0][1]) seen = 1'b1;
      end
      alive[20:17] = 4'b1111;
      chk("rearm_pulse_seen", 32'(seen), 32'd1);
      chk("rearm_enough_ticks", 32'(tick_q.size() >= 2), 32'd1);
      if (tick_q.size() >= 2) chk("rearm_full_delay", 32'(last_pe[0][1]), 32'(tick_q[1] + 1));
      steps(20);

      // frozen for 500 frames with mosquitoes dead: nothing until play resumes
      for (int g = 0; g < 3; g++) begin
         base[0][g] = pc[0][g];
         base[1][g] = pc[1][g];
      end
      game_active = 1'b0;
      alive[22:21] = 2'b00;
      steps(2000);
      chk("freeze_pulses_a", 32'(pc[0][0] + pc[0][1] + pc[0][2]),
          32'(base[0][0] + base[0][1] + base[0][2]));
      chk("freeze_pulses_b", 32'(pc[1][0] + pc[1][1] + pc[1][2]),
          32'(base[1][0] + base[1][1] + base[1][2]));
      game_active = 1'b1;
      re = edge_n;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         if (pc[1][2] != base[1][2]) seen = 1'b1;
      end
      alive[22:21] = 2'b11;
      chk("resume_pulse_seen", 32'(seen), 32'd1);
      chk("resume_not_immediate", 32'(last_pe[1][2] - re > 3), 32'd1);
      steps(20);

      // randomized play with random ticks and freezes
      rand_tick = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         int r;
         int g;
         step();
         r = $urandom_range(0, 99);
         if (r < 2) begin
            g = $urandom_range(0, 2);
            for (int b = grp_lo[g]; b <= grp_hi[g]; b++) alive[b] = 1'b0;
         end else if (r < 7) alive[$urandom_range(0, EC - 1)] = 1'b0;
         else if (r < 11) alive[$urandom_range(0, EC - 1)] = 1'b1;
         if ($urandom_range(0, 99) < 2) game_active = ~game_active;
      end
      rand_tick = 1'b0;
      game_active = 1'b1;
      alive = '1;
      steps(20);

      // reset while fly is WAIT (inst a) and READY (inst b): nothing may leak out
      for (int g = 0; g < 3; g++) begin
         base[0][g] = pc[0][g];
         base[1][g] = pc[1][g];
      end
      alive[16:0] = '0;
      step();
      #5 rst_n = 1'b0;
      model_reset();
      alive = '1;
      #1;
      chk("rst_fly_a", 32'(bus_a.reset_fly), 32'd0);
      chk("rst_fly_b", 32'(bus_b.reset_fly), 32'd0);
      chk("rst_wave_a", 32'(bus_a.wave_count), 32'd0);
      chk("rst_wave_b", 32'(bus_b.wave_count), 32'd0);
      steps(3);
      #5 rst_n = 1'b1;
      steps(50);
      chk("rst_no_pulse_a", 32'(pc[0][0] + pc[0][1] + pc[0][2]),
          32'(base[0][0] + base[0][1] + base[0][2]));
      chk("rst_no_pulse_b", 32'(pc[1][0] + pc[1][1] + pc[1][2]),
          32'(base[1][0] + base[1][1] + base[1][2]));

      // kill counting from a fresh reset
      alive[0]  = 1'b0;
      alive[5]  = 1'b0;
      alive[17] = 1'b0;
      step();
`ifdef KILL_COUNT_EN
      chk("kill_three", 32'(bus_a.kill_count), 32'd3);
`else
      chk("kill_tied_zero", 32'(bus_a.kill_count), 32'd0);
`endif
      alive[0] = 1'b1;
      step();
      alive[0] = 1'b0;
      step();
`ifdef KILL_COUNT_EN
      chk("kill_four", 32'(bus_b.kill_count), 32'd4);
`else
      chk("kill_still_zero", 32'(bus_b.kill_count), 32'd0);
`endif
      alive = '1;
      steps(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/enemy_respawn_scheduler.md
Name: enemy_respawn_scheduler

Overview:
Sequences group respawns for the enemy hit/alive datapath. Watches the registered 23-bit alive vector and detects when a whole group (fly 0-16, spider 17-20, mosquito 21-22) is wiped out. After a per-group frame delay, it issues the one-cycle reset_fly / reset_spider / reset_mosquito pulses that drive the alive controller's group reset inputs. At most one group reset is issued per cycle, through a fixed-priority arbiter. It also counts completed respawn waves for the HUD/difficulty logic.

Parameters:
ENEMY_COUNT, 23, width of the alive vector
FLY_LAST, 16, highest fly index (flies are 0..FLY_LAST)
SPIDER_LAST, 20, highest spider index (spiders are FLY_LAST+1..SPIDER_LAST; mosquitoes are SPIDER_LAST+1..ENEMY_COUNT-1)
FLY_DELAY, 60, frames from fly wipe-out to fly respawn request
SPIDER_DELAY, 90, frames for the spider group
MOSQ_DELAY, 120, frames for the mosquito group
DELAY_W, 8, countdown width; every delay must be < 2^DELAY_W

Ports:
clk25  input  1  system clock, 25 MHz pixel clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per video frame
game_active  input  1  1 = play running; 0 = freeze all scheduling
enemy_alive  input  ENEMY_COUNT  bit i = enemy i alive, registered output of the alive controller
reset_fly  output  1  one-cycle respawn pulse for the fly group
reset_spider  output  1  one-cycle respawn pulse for the spider group
reset_mosquito  output  1  one-cycle respawn pulse for the mosquito group
wave_count  output  8  number of respawn pulses issued, saturating
kill_count  output  16  enemies killed (present only with KILL_COUNT_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): all group FSMs go to GUARD with guard counter 2. All reset_* outputs = 0, wave_count = 0, kill_count = 0.
- Per-group FSM, three independent instances: ALIVE, WAIT, READY, GUARD.
  - ALIVE: if group_dead (AND of the group's ~alive bits) && game_active, load cnt = group delay and go to WAIT.
  - WAIT: on frame_tick && game_active, decrement cnt. When cnt==1 and frame_tick arrives, go to READY. A delay of 0 goes straight from ALIVE to READY on the next cycle. If any group bit returns to 1 while in WAIT, go back to ALIVE.
  - READY: assert a request to the arbiter. When granted, go to GUARD with guard = 2.
  - GUARD: ignore group_dead for 2 clk25 cycles, because the alive controller's registered output lags the reset pulse by one cycle. Then go to ALIVE.
- Arbiter: fixed priority fly > spider > mosquito.
  - The grant is registered, so the reset_* output is high for exactly the cycle after grant; exactly one output may be high in any cycle.
  - A losing request stays in READY and is granted in a later cycle. Worst case, mosquito is granted 2 cycles after all three reach READY together.
- Freeze: game_active=0 holds all counters and FSM states, and no grants are issued. Requests still pending in READY are issued after game_active returns to 1.
- Simultaneous frame_tick and grant: they are independent; a group in WAIT still decrements.
- wave_count: increments by 1 per reset_* pulse and saturates at 255.
- Reset asserted mid-WAIT: state, counter and any pending grant are discarded; no pulse is emitted.
- Latency: a group reaching READY at cycle t with no competitor produces its reset_* pulse at cycle t+1.

Optional Feature:
KILL_COUNT_EN:
- Defined: register enemy_alive as prev_alive. Each cycle, kill_count += popcount(prev_alive & ~enemy_alive), i.e. 1→0 transitions. kill_count saturates at 16'hFFFF. Respawn (0→1) transitions do not count. The rst_n state of prev_alive is all 1s.
- Not defined: kill_count is tied to 0 and no prev_alive register exists.

Test Plan:
- Reset release with enemy_alive all 1s → all reset_* outputs stay 0 for 1000 cycles; wave_count = 0.
- Clear bits 21-22 with FLY/SPIDER alive and MOSQ_DELAY = 3 → reset_mosquito pulses exactly once, one cycle after the 3rd frame_tick; wave_count = 1.
- Drive all 23 bits to 0 with all delays = 2 and simultaneous ticks → reset_fly, reset_spider, reset_mosquito pulse on three consecutive cycles in that order; wave_count = 3.
- Spider group dead, then set bit 18 back to 1 after 1 tick in WAIT → no reset_spider pulse; FSM back in ALIVE.
- Mosquitoes dead with game_active = 0 for 500 ticks → no pulse; counting resumes only after game_active = 1.
- KILL_COUNT_EN: clear bits 0, 5 and 17 in one cycle → kill_count = 3 next cycle; respawn and re-clear bit 0 → kill_count = 4.
